// File: rtl/hex_display_pkg.sv
// Shared types, idle output codes and the active-low hex-to-segment table
// for the multiplexed seven-segment display driver.
package hex_display_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Segment order {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure table lookup; the shared function keeps one copy of the glyph set.
    always_comb begin
        o_seg = hex2seg(i_nibble);
    end

endmodule

// File: rtl/hex_display_scan.sv
// Eight-digit time-multiplexed hex display driver: dead time between digits,
// one coherent data snapshot per frame, optional leading-zero blanking.
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int DEAD_CYCLES  = 1000,
    parameter int LZB_EN       = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [31:0] data_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [31:0]      r_frame;
    logic             w_snap;
    logic [31:0]      w_upper;
    logic             w_blank;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg_dec;
    logic [7:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    // Scan state, dwell counter and digit index registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= DEAD;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: dark for DEAD_CYCLES, lit for DIGIT_CYCLES, then advance digit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        case (r_state)
            DEAD: begin
                if (r_cnt == DEAD_LAST) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = DEAD;
                end
            end
            ON: begin
                if (r_cnt == DIGIT_LAST) begin
                    w_state_nxt = DEAD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 3'd1;
                end else begin
                    w_state_nxt = ON;
                end
            end
            default: begin
                w_state_nxt = DEAD;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    assign w_snap = (r_state == DEAD) && (r_idx == 3'd0) && (r_cnt == '0);

    // Frame snapshot, taken only at the very start of each frame so digits never tear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame <= 32'd0;
        end else if (w_snap) begin
            r_frame <= data_i;
        end else begin
            r_frame <= r_frame;
        end
    end

    assign w_upper  = r_frame >> {r_idx, 2'b00};
    assign w_blank  = (LZB_EN != 0) && (r_idx != 3'd0) && (w_upper == 32'd0);
    assign w_nibble = r_frame[{r_idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    // Output decode; anything other than a lit, visible digit drives everything off.
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        if ((r_state == ON) && en_i && !w_blank) begin
            w_an_nxt  = ~(8'b0000_0001 << r_idx);
            w_seg_nxt = w_seg_dec;
        end else begin
            w_an_nxt  = AN_OFF;
            w_seg_nxt = SEG_OFF;
        end
    end

    // Registered pad drivers; reset forces them off without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= 1'b1;
        end
    end

    assign an_o  = r_an;
    assign seg_o = r_seg;
    assign dp_o  = r_dp;

endmodule
